// File: rtl/alarm_pkg.sv
// Shared types, tone selectors, the pattern ROM and the tone half-period helper.
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, TONE, GAP, LOCKOUT} state_e;

  localparam logic [1:0] T_SIL = 2'd0;
  localparam logic [1:0] T_400 = 2'd1;
  localparam logic [1:0] T_1K  = 2'd2;
  localparam logic [1:0] T_2K  = 2'd3;

  typedef enum logic {DUR_TONE, DUR_GAP} dur_e;

  typedef struct packed {
    logic [1:0] tone;
    dur_e       dur;
    logic       last;
  } rom_entry_t;

  // Success pattern occupies steps 0..2, fail pattern steps 3..7.
  localparam logic [2:0] SUCC_BASE = 3'd0;
  localparam logic [2:0] FAIL_BASE = 3'd3;

  function automatic rom_entry_t rom(input logic [2:0] step);
    case (step)
      3'd0:    return '{tone: T_1K,  dur: DUR_TONE, last: 1'b0};
      3'd1:    return '{tone: T_SIL, dur: DUR_GAP,  last: 1'b0};
      3'd2:    return '{tone: T_2K,  dur: DUR_TONE, last: 1'b1};
      3'd3:    return '{tone: T_400, dur: DUR_TONE, last: 1'b0};
      3'd4:    return '{tone: T_SIL, dur: DUR_GAP,  last: 1'b0};
      3'd5:    return '{tone: T_400, dur: DUR_TONE, last: 1'b0};
      3'd6:    return '{tone: T_SIL, dur: DUR_GAP,  last: 1'b0};
      default: return '{tone: T_400, dur: DUR_TONE, last: 1'b1};
    endcase
  endfunction

  // Half-period in clk cycles, integer-truncated: clk_hz / (2 * f).
  function automatic int unsigned half_period(input int unsigned clk_hz, input logic [1:0] sel);
    case (sel)
      T_400:   return clk_hz / 800;
      T_1K:    return clk_hz / 2000;
      T_2K:    return clk_hz / 4000;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/alarm_sequencer_tone_osc.sv
// Square-wave oscillator: counts half-periods of the selected tone and toggles.
// Phase restarts (wave = 0, count = 0) whenever it was disabled in the previous
// cycle or the tone selection changes, so every burst begins identically.
module tone_osc
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] tone_sel,
  output logic       wave
);

  localparam int unsigned HMAX = half_period(CLK_HZ, T_400);
  localparam int unsigned HP_W = $clog2(HMAX + 1);

  logic [HP_W-1:0] cnt_q, cnt_d, half_m1;
  logic            wave_q, wave_d;
  logic            en_q;
  logic [1:0]      sel_q;

  assign half_m1 = HP_W'(half_period(CLK_HZ, tone_sel) - 1);
  assign wave    = wave_q;

  // Next phase: clear on disable/restart, otherwise count and toggle at half-period.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cnt_d  = cnt_q + 1'b1;
    wave_d = wave_q;
    if (!en || !en_q || (tone_sel != sel_q)) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (cnt_q >= half_m1) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end
  end

  // Phase registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with <= so all flops sample pre-edge values together.
    if (rst) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
      en_q   <= 1'b0;
      sel_q  <= T_SIL;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
      en_q   <= en;
      sel_q  <= tone_sel;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Tone pattern player and failed-attempt lockout following PIN verification.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TONE_MS    = 100,
  parameter int unsigned GAP_MS     = 50,
  parameter int unsigned LOCK_FAILS = 3,
  parameter int unsigned LOCK_S     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       success_event,
  input  logic       fail_event,
  output logic       audio_out,
  output logic       busy,
  output logic       lockout,
  output logic [2:0] fail_count
);

  // 64-bit products: TONE_MS * CLK_HZ overflows 32 bits at realistic clocks.
  localparam int unsigned TONE_CYC = 32'((64'(TONE_MS) * 64'(CLK_HZ)) / 64'd1000);
  localparam int unsigned GAP_CYC  = 32'((64'(GAP_MS) * 64'(CLK_HZ)) / 64'd1000);
  localparam int unsigned LOCK_CYC = 32'(64'(LOCK_S) * 64'(CLK_HZ));
  localparam int unsigned GATE_CYC = 32'((64'd250 * 64'(CLK_HZ)) / 64'd1000);
  localparam int unsigned DUR_MAX  = (LOCK_CYC > TONE_CYC) ?
                                     ((LOCK_CYC > GAP_CYC) ? LOCK_CYC : GAP_CYC) :
                                     ((TONE_CYC > GAP_CYC) ? TONE_CYC : GAP_CYC);
  localparam int unsigned DUR_W    = $clog2(DUR_MAX + 1);
  localparam int unsigned GATE_W   = $clog2(GATE_CYC + 1);

  logic [1:0] succ_sync_q, fail_sync_q;
  logic       succ_last_q, fail_last_q, succ_p_q, fail_p_q;

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [2:0]        fc_q, fc_d, fc_inc;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic              gate_on_q, gate_on_d;
  rom_entry_t        cur, nxt;
  logic              osc_en;
  logic [1:0]        osc_sel;

  function automatic logic [DUR_W-1:0] reload(input dur_e d);
    return (d == DUR_GAP) ? DUR_W'(GAP_CYC - 1) : DUR_W'(TONE_CYC - 1);
  endfunction

  // Two-flop synchronizers plus registered rising-edge detectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      succ_sync_q <= '0;
      fail_sync_q <= '0;
      succ_last_q <= 1'b0;
      fail_last_q <= 1'b0;
      succ_p_q    <= 1'b0;
      fail_p_q    <= 1'b0;
    end else begin
      succ_sync_q <= {succ_sync_q[0], success_event};
      fail_sync_q <= {fail_sync_q[0], fail_event};
      succ_last_q <= succ_sync_q[1];
      fail_last_q <= fail_sync_q[1];
      succ_p_q    <= succ_sync_q[1] & ~succ_last_q;
      fail_p_q    <= fail_sync_q[1] & ~fail_last_q;
    end
  end

  assign cur    = rom(step_q);
  assign nxt    = rom(3'(step_q + 3'd1));
  assign fc_inc = (fc_q < 3'(LOCK_FAILS)) ? 3'(fc_q + 3'd1) : fc_q;

  // Next-state, step, duration and fail-count logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    fc_d    = fc_q;
    dur_d   = (dur_q != '0) ? DUR_W'(dur_q - 1'b1) : dur_q;
    case (state_q)
      IDLE: begin
        if (fail_p_q) begin
          fc_d    = fc_inc;
          step_d  = FAIL_BASE;
          state_d = TONE;
          dur_d   = reload(DUR_TONE);
        end else if (succ_p_q) begin
          fc_d    = '0;
          step_d  = SUCC_BASE;
          state_d = TONE;
          dur_d   = reload(DUR_TONE);
        end
      end
      TONE, GAP: begin
        if (fail_p_q) fc_d = fc_inc;
        if (dur_q == '0) begin
          if (cur.last) begin
            if ((step_q >= FAIL_BASE) && (fc_q == 3'(LOCK_FAILS))) begin
              state_d = LOCKOUT;
              dur_d   = DUR_W'(LOCK_CYC - 1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            step_d  = 3'(step_q + 3'd1);
            state_d = (nxt.dur == DUR_GAP) ? GAP : TONE;
            dur_d   = reload(nxt.dur);
          end
        end
      end
      LOCKOUT: begin
        if (dur_q == '0) begin
          fc_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lockout on/off gating; restarts "on" at every lockout entry.
  always_comb begin
    gate_cnt_d = GATE_W'(gate_cnt_q + 1'b1);
    gate_on_d  = gate_on_q;
    if ((state_d != LOCKOUT) || (state_q != LOCKOUT)) begin
      gate_cnt_d = '0;
      gate_on_d  = 1'b1;
    end else if (gate_cnt_q == GATE_W'(GATE_CYC - 1)) begin
      gate_cnt_d = '0;
      gate_on_d  = ~gate_on_q;
    end
  end

  // The oscillator is fed next-cycle values so its registered wave lines up with state.
  assign osc_en  = (state_d == TONE) || ((state_d == LOCKOUT) && gate_on_d);
  assign osc_sel = (state_d == LOCKOUT) ? T_2K : rom(step_d).tone;

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      dur_q      <= '0;
      fc_q       <= '0;
      gate_cnt_q <= '0;
      gate_on_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dur_q      <= dur_d;
      fc_q       <= fc_d;
      gate_cnt_q <= gate_cnt_d;
      gate_on_q  <= gate_on_d;
    end
  end

  tone_osc #(.CLK_HZ(CLK_HZ)) u_osc (
    .clk      (clk),
    .rst      (rst),
    .en       (osc_en),
    .tone_sel (osc_sel),
    .wave     (audio_out)
  );

  assign busy       = (state_q != IDLE);
  assign lockout    = (state_q == LOCKOUT);
  assign fail_count = fc_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: expected waveforms are built as segment lists
// (tone half-period, length) straight from the pattern description.
module tb_alarm_sequencer;

  localparam int CLK_HZ = 10_000, TONE_MS = 100, GAP_MS = 50, LOCK_FAILS = 3, LOCK_S = 1;
  localparam int TONE_C = TONE_MS * CLK_HZ / 1000;
  localparam int GAP_C  = GAP_MS * CLK_HZ / 1000;
  localparam int LOCK_C = LOCK_S * CLK_HZ;
  localparam int GATE_C = 250 * CLK_HZ / 1000;
  localparam int H400 = CLK_HZ / 800, H1K = CLK_HZ / 2000, H2K = CLK_HZ / 4000;

  logic clk = 1'b0, rst = 1'b1, success_event = 1'b0, fail_event = 1'b0;
  logic audio_out, busy, lockout;
  logic [2:0] fail_count;

  alarm_sequencer #(.CLK_HZ(CLK_HZ), .TONE_MS(TONE_MS), .GAP_MS(GAP_MS),
                    .LOCK_FAILS(LOCK_FAILS), .LOCK_S(LOCK_S)) dut (
    .clk(clk), .rst(rst), .success_event(success_event), .fail_event(fail_event),
    .audio_out(audio_out), .busy(busy), .lockout(lockout), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  typedef struct { int half; int len; bit lock; } seg_t;
  seg_t segs[$];
  int   model_fc = 0;
  int   n_cmp = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic int fc_after_fail(input int fc);
    return (fc < LOCK_FAILS) ? fc + 1 : fc;
  endfunction

  // Launch an event, then compare every cycle of the expected waveform.
  // inj_kind: 0 none, 1 fail rise at cycle inj_at, 2 success rise at inj_at.
  task automatic fire(input bit s, input bit f, input int inj_at, input int inj_kind,
                      input string tag);
    int pat_len, t_all, errs;
    pat_len = f ? (3 * TONE_C + 2 * GAP_C) : (2 * TONE_C + GAP_C);
    model_fc = f ? fc_after_fail(model_fc) : 0;
    if (inj_kind == 1 && inj_at < pat_len - 8) model_fc = fc_after_fail(model_fc);
    segs.delete();
    if (!f) begin
      segs.push_back('{H1K, TONE_C, 1'b0});
      segs.push_back('{0, GAP_C, 1'b0});
      segs.push_back('{H2K, TONE_C, 1'b0});
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (b > 0) segs.push_back('{0, GAP_C, 1'b0});
        segs.push_back('{H400, TONE_C, 1'b0});
      end
      if (model_fc == LOCK_FAILS)
        for (int t = 0; t < LOCK_C; t += GATE_C)
          segs.push_back('{((t / GATE_C) % 2 == 0) ? H2K : 0,
                           (LOCK_C - t < GATE_C) ? LOCK_C - t : GATE_C, 1'b1});
    end
    success_event = s;
    fail_event    = f;
    idle(3);
    check({tag, " busy_before_latency"}, 32'(busy), 32'd0);
    tick();
    t_all = 0;
    for (int i = 0; i < segs.size(); i++) begin
      errs = 0;
      for (int c = 0; c < segs[i].len; c++) begin
        if (busy !== 1'b1 || lockout !== segs[i].lock ||
            audio_out !== ((segs[i].half == 0) ? 1'b0 : 1'(((c / segs[i].half) % 2))))
          errs++;
        if (t_all == 2) begin success_event = 0; fail_event = 0; end
        if (t_all == inj_at) begin
          if (inj_kind == 1) fail_event = 1;
          if (inj_kind == 2) success_event = 1;
        end
        if (t_all == inj_at + 5) begin success_event = 0; fail_event = 0; end
        tick();
        t_all++;
      end
      check($sformatf("%s seg%0d bad_cycles", tag, i), 32'(errs), 32'd0);
    end
    if (segs[segs.size()-1].lock) model_fc = 0;
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " lockout_end"}, 32'(lockout), 32'd0);
    check({tag, " fail_count"}, 32'(fail_count), 32'(model_fc));
  endtask

  initial begin
    idle(3);
    check("reset audio", 32'(audio_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset lockout", 32'(lockout), 32'd0);
    check("reset fail_count", 32'(fail_count), 32'd0);
    rst = 1'b0;
    idle(5);

    fire(1, 0, -1, 0, "succ");
    idle(10);
    fire(0, 1, -1, 0, "fail1");
    idle(10);
    fire(0, 1, -1, 0, "fail2");
    idle(10);
    // Third fail leads to lockout; the extra fail during lockout must be ignored.
    fire(0, 1, 3 * TONE_C + 2 * GAP_C + 500, 1, "fail3_lock");
    idle(10);

    fire(0, 1, -1, 0, "ffsf_f1");
    idle(7);
    fire(0, 1, -1, 0, "ffsf_f2");
    idle(7);
    fire(1, 0, -1, 0, "ffsf_s");
    idle(7);
    fire(0, 1, -1, 0, "ffsf_f3");
    idle(7);

    fire(1, 0, -1, 0, "clear");
    idle(7);
    // Simultaneous rise: fail wins; second fail mid-pattern counts but does not restart.
    fire(1, 1, 1500, 1, "both_then_fail");
    idle(7);
    fire(1, 0, 600, 2, "succ_mid_succ");
    idle(7);

    for (int r = 0; r < 3; r++) begin
      bit is_f;
      int kind;
      is_f = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      fire(~is_f, is_f, int'($urandom_range(10, 2000)), kind, $sformatf("rand%0d", r));
      idle(int'($urandom_range(3, 30)));
    end

    // Reset in the middle of a tone.
    fire(1, 0, -1, 0, "pre_rst_clear");
    idle(5);
    fail_event = 1'b1;
    idle(4);
    fail_event = 1'b0;
    idle(300);
    check("pre_rst audio", 32'(audio_out), 32'((300 / H400) % 2));
    check("pre_rst fail_count", 32'(fail_count), 32'd1);
    rst = 1'b1;
    #1;
    check("rst audio", 32'(audio_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst fail_count", 32'(fail_count), 32'd0);
    model_fc = 0;
    idle(3);
    rst = 1'b0;
    idle(5);
    fire(1, 0, -1, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
